// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, with start/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  localparam int CNT_W = $clog2(2*WIDTH+1);
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(2*WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH:0]       prem_q, prem_d;
  logic [2*WIDTH-1:0]   quo_q, quo_d;
  logic [2*WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH:0]       shifted;
  logic [WIDTH+1:0]     trial;

  // The partial remainder stays below the divisor, so its top bit is always
  // zero before the shift and nothing is lost.
  assign shifted = {prem_q[WIDTH-1:0], dvd_q[2*WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    if (state_q == RUN) begin
      if (trial[WIDTH+1]) begin
        prem_d = shifted;
        quo_d  = {quo_q[2*WIDTH-2:0], 1'b0};
      end else begin
        prem_d = trial[WIDTH:0];
        quo_d  = {quo_q[2*WIDTH-2:0], 1'b1};
      end
      dvd_d = {dvd_q[2*WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d     = DONE;
        quotient_d  = quo_d;
        remainder_d = prem_d[WIDTH-1:0];
      end
    end else if (start) begin
      // Accepted from IDLE or DONE (back-to-back).
      dvd_d = dividend;
      dvs_d = divisor;
      dbz_d = 1'b0;
      if (divisor == '0) begin
        state_d     = DONE;
        quotient_d  = '1;
        remainder_d = '0;
        dbz_d       = 1'b1;
      end else begin
        prem_d  = '0;
        quo_d   = '0;
        cnt_d   = ITERS;
        state_d = RUN;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized
// operands checked against plain integer division.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] dividend;
  logic [4:0] divisor;
  logic       busy;
  logic       done;
  logic [9:0] quotient;
  logic [4:0] remainder;
  logic       div_by_zero;

  int compared = 0;
  int mismatched = 0;

  seq_divider #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One division. inject=1 pulses a competing start (900/30) while busy and
  // then verifies no further done pulse appears.
  task automatic run_op(input int a, input int b, input int inject, input string tag);
    int exp_q, exp_r, exp_z, exp_lat, exp_busy;
    int lat, busy_cycles, extra_done;
    exp_z    = (b == 0) ? 1 : 0;
    exp_q    = (b == 0) ? 1023 : a / b;
    exp_r    = (b == 0) ? 0 : a % b;
    exp_lat  = (b == 0) ? 1 : 11;
    exp_busy = (b == 0) ? 0 : 10;
    @(negedge clk);
    dividend = 10'(a);
    divisor  = 5'(b);
    start    = 1'b1;
    lat = 0;
    busy_cycles = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        start    = 1'b0;
        dividend = 10'($urandom);
        divisor  = 5'($urandom);
      end
      if (inject != 0 && e == 4) begin
        start = 1'b1; dividend = 10'd900; divisor = 5'd30;
      end
      if (inject != 0 && e == 5) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        lat = e;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cycles, exp_busy);
    check({tag, " quotient"}, int'(quotient), exp_q);
    check({tag, " remainder"}, int'(remainder), exp_r);
    check({tag, " div_by_zero"}, int'(div_by_zero), exp_z);
    check({tag, " invariant"}, (b == 0) ? a : int'(quotient) * b + int'(remainder), a);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, int'(done), 0);
    if (inject != 0) begin
      extra_done = 0;
      for (int e = 0; e < 15; e++) begin
        @(posedge clk); #1;
        if (done || busy) extra_done++;
      end
      check({tag, " no_second_op"}, extra_done, 0);
    end
    $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b,
             quotient, remainder, div_by_zero, lat);
  endtask

  initial begin
    int last, pulses, a, b, stray;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(961, 31, 0, "961/31");
    run_op(100, 7, 0, "100/7");
    run_op(5, 17, 0, "5/17");
    run_op(1023, 1, 0, "1023/1");
    run_op(500, 0, 0, "500/0");
    run_op(100, 7, 1, "ignore_busy_start");

    // Back-to-back: start held high, a new op is accepted in every DONE cycle.
    @(negedge clk);
    dividend = 10'd961; divisor = 5'd31; start = 1'b1;
    last = 0; pulses = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        check("b2b spacing", e - last, 11);
        check("b2b quotient", int'(quotient), 31);
        check("b2b remainder", int'(remainder), 0);
        $display("b2b pulse %0d at edge %0d q=%0d r=%0d", pulses, e, quotient, remainder);
        last = e;
      end
    end
    start = 1'b0;
    check("b2b pulses", pulses, 3);
    repeat (15) @(posedge clk);

    // Reset in the middle of a run.
    @(negedge clk);
    dividend = 10'd100; divisor = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst busy_before", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst quotient", int'(quotient), 0);
    check("midrst remainder", int'(remainder), 0);
    stray = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    check("midrst no_done", stray, 0);
    $display("mid-run reset: busy=%0d done=%0d q=%0d r=%0d", busy, done, quotient, remainder);
    run_op(100, 7, 0, "after_reset_100/7");

    // Multiplier cross-check: (A*B)/B == A r0.
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(31, 1);
      b = $urandom_range(31, 1);
      run_op(a * b, b, 0, $sformatf("mul_xchk_%0d", i));
      check("mul_xchk operand", int'(quotient), a);
    end
    // Fully random operands, divisor zero included occasionally.
    for (int i = 0; i < 20; i++) begin
      run_op($urandom_range(1023, 0), $urandom_range(31, 0), 0, $sformatf("rand_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider: the inverse of the team's 5x5 Wallace tree multiplier.
- Takes a 2*WIDTH-bit dividend (multiplier product width) and a WIDTH-bit divisor.
- Produces quotient and remainder at one quotient bit per clock, with start/busy/done handshake.
- Used to recover an operand from a product, or for general integer division, in the arithmetic datapath next to the multiplier.

Parameters:
- WIDTH, 5, divisor/remainder width; dividend and quotient are 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  2*WIDTH  unsigned dividend; captured on accepted start.
- divisor  input  WIDTH  unsigned divisor; captured on accepted start.
- busy  output  1  high while a division is in progress (RUN state).
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  2*WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder, always < divisor when divisor != 0.
- div_by_zero  output  1  set with done when the captured divisor was 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high, and has priority over all other inputs.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Reset clears internal state: FSM to IDLE, iteration counter 0, working registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures dividend and divisor, clears div_by_zero.
  - If divisor==0, go to DONE directly.
  - Otherwise clear the partial remainder (WIDTH+1 bits), load the counter with 2*WIDTH, go to RUN.
- RUN, each cycle:
  - Shift the partial remainder left, bringing in the current dividend MSB.
  - Trial subtract the divisor (WIDTH+1-bit arithmetic).
  - If non-negative, keep the difference and shift 1 into the quotient; else keep the shifted value and shift 0.
  - Decrement the counter. After the 2*WIDTH-th iteration, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - quotient and remainder registers are updated on the DONE-entry edge.
  - Next state is IDLE.
- Divide by zero: quotient=all ones (2^(2*WIDTH)-1), remainder=0, div_by_zero=1.
- Latency:
  - Normal case: done is high in the cycle starting 2*WIDTH+1 edges after the edge that sampled start (11 for WIDTH=5).
  - Divide by zero: done is high in the cycle starting 1 edge after the sampling edge.
- Handshake:
  - busy=1 only in RUN.
  - start is ignored while busy=1.
  - start in the DONE cycle is accepted (back-to-back operation), so a new RUN follows immediately.
- Output hold: quotient, remainder and div_by_zero hold their last results until the next DONE or reset. Internal working registers are separate from the output registers.
- Operand capture: inputs may change freely after the accepting edge; only captured copies are used.
- Reset mid-operation: rst during RUN aborts the division. Next cycle: IDLE, busy=0, done=0, outputs zeroed. No done pulse is produced for the aborted operation.
- Arithmetic: all unsigned. Quotient is full 2*WIDTH bits (no overflow possible). Invariant: dividend = quotient*divisor + remainder.

Test Plan:
- Reset then start with dividend=961, divisor=31 -> exactly 11 cycles later done=1, quotient=31, remainder=0, div_by_zero=0; busy high for 10 cycles.
- dividend=100, divisor=7 -> quotient=14, remainder=2. Then dividend=5, divisor=17 -> quotient=0, remainder=5. Then dividend=1023, divisor=1 -> quotient=1023, remainder=0.
- dividend=500, divisor=0 -> done 1 cycle after start, div_by_zero=1, quotient=1023, remainder=0, busy never high.
- start with 100/7, then start with 900/30 pulsed on cycle 4 while busy -> the second request is ignored; result is 14 r2 with a single done pulse.
- Hold start=1 continuously with 961/31 -> new operation accepted in each DONE cycle; done pulses every 11 cycles with quotient=31, remainder=0.
- Assert rst during RUN at cycle 5 -> next cycle busy=0, done=0, quotient=0, remainder=0, no done pulse. A subsequent 100/7 then returns 14 r2.
- Randomized cross-check against the multiplier (A,B in 1..31): divide A*B by B -> quotient=A, remainder=0.
